branch_predictor_ctrl: RTL and testbench

Controller for the branch-prediction table in the RISC-V core. The table holds 2-bit saturating counters in an external single-port, synchronous-read memory. This block clears the table after reset, then arbitrates between fetch-stage lookups and execute-stage updates, issuing one memory operation per cycle. Updates are buffered in a small queue, and pending updates are forwarded to lookups.

---
 rtl/branch_predictor_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_branch_predictor_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_ctrl.sv
// branch_predictor_ctrl
// Controller for a table of 2-bit saturating branch counters held in an
// external single-port, synchronous-read memory. After reset it writes
// 2'b01 to every entry, then arbitrates fetch lookups against buffered
// execute-stage updates, issuing at most one memory operation per cycle.
// Pending queued updates are forwarded to lookups of the same index.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   lookupValid/lookupPc/lookupReady   fetch-side prediction request
//   predictValid/predictTaken/predictCtr  prediction result (1-cycle latency)
//   updateValid/updatePc/updateTaken/updateCtr/updateReady  resolved branch
//   memEn/memWe/memAddr/memWdata/memRdata  table memory port
//   initDone                       table clear complete
module branch_predictor_ctrl #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES),
    parameter int unsigned QDEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookupValid,
    input  logic [31:0]      lookupPc,
    output logic             lookupReady,
    output logic             predictValid,
    output logic             predictTaken,
    output logic [1:0]       predictCtr,
    input  logic             updateValid,
    input  logic [31:0]      updatePc,
    input  logic             updateTaken,
    input  logic [1:0]       updateCtr,
    output logic             updateReady,
    output logic             memEn,
    output logic             memWe,
    output logic [IDX_W-1:0] memAddr,
    output logic [1:0]       memWdata,
    input  logic [1:0]       memRdata,
    output logic             initDone
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(QDEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] initIdx;

    // Update queue storage; validity is tracked by rdPtr/count only.
    logic [IDX_W-1:0] qIdx [QDEPTH];
    logic [1:0]       qCtr [QDEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;

    logic             fwdHit;
    logic [1:0]       fwdCtr;
    logic [1:0]       heldCtr;

    logic             running;
    logic             full;
    logic             empty;
    logic             lookupAcc;
    logic             updateAcc;
    logic             deq;
    logic [IDX_W-1:0] lookupIdx;
    logic [IDX_W-1:0] updateIdx;
    logic [1:0]       newCtr;
    logic             hitD;
    logic [1:0]       hitCtrD;
    logic             unusedPc;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign lookupIdx = lookupPc[IDX_W+1:2];
    assign updateIdx = updatePc[IDX_W+1:2];
    assign unusedPc  = ^{lookupPc[31:IDX_W+2], lookupPc[1:0],
                         updatePc[31:IDX_W+2], updatePc[1:0]};

    assign running     = (state == ST_RUN);
    assign full        = (count == Q_FULL);
    assign empty       = (count == '0);
    assign lookupReady = running && !full;
    assign updateReady = running && !full;
    assign lookupAcc   = lookupValid && lookupReady;
    assign updateAcc   = updateValid && updateReady;

    // Saturating counter step for the resolved branch.
    always_comb begin
        if (updateTaken) begin
            newCtr = (updateCtr == 2'd3) ? 2'd3 : updateCtr + 2'd1;
        end else begin
            newCtr = (updateCtr == 2'd0) ? 2'd0 : updateCtr - 2'd1;
        end
    end

    // Forwarding: walk oldest to youngest so the last match wins; a
    // same-cycle enqueue is younger than anything already queued.
    always_comb begin
        logic [PTR_W-1:0] pos;
        hitD    = 1'b0;
        hitCtrD = 2'b00;
        pos     = rdPtr;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if ((CNT_W'(i) < count) && (qIdx[pos] == lookupIdx)) begin
                hitD    = 1'b1;
                hitCtrD = qCtr[pos];
            end
            pos = nextPtr(pos);
        end
        if (updateAcc && (updateIdx == lookupIdx)) begin
            hitD    = 1'b1;
            hitCtrD = newCtr;
        end
    end

    // Memory port arbitration. A full queue drains before lookups are served
    // so updates cannot be starved by a continuous fetch stream.
    always_comb begin
        memEn    = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = 2'b00;
        deq      = 1'b0;
        if (state == ST_INIT) begin
            memEn    = 1'b1;
            memWe    = 1'b1;
            memAddr  = initIdx;
            memWdata = 2'b01;
        end else if (full || (!lookupValid && !empty)) begin
            memEn    = 1'b1;
            memWe    = 1'b1;
            memAddr  = qIdx[rdPtr];
            memWdata = qCtr[rdPtr];
            deq      = 1'b1;
        end else if (lookupValid) begin
            memEn   = 1'b1;
            memAddr = lookupIdx;
        end
    end

    // Read data is only meaningful in the cycle after a read; hold otherwise.
    assign predictCtr   = predictValid ? (fwdHit ? fwdCtr : memRdata) : heldCtr;
    assign predictTaken = predictCtr[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            initIdx      <= '0;
            initDone     <= 1'b0;
            rdPtr        <= '0;
            wrPtr        <= '0;
            count        <= '0;
            predictValid <= 1'b0;
            fwdHit       <= 1'b0;
            fwdCtr       <= 2'b00;
            heldCtr      <= 2'b00;
        end else begin
            if (state == ST_INIT) begin
                initIdx <= initIdx + 1'b1;
                if (initIdx == IDX_LAST) begin
                    state    <= ST_RUN;
                    initDone <= 1'b1;
                end
            end
            if (updateAcc) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (deq) begin
                rdPtr <= nextPtr(rdPtr);
            end
            count        <= count + CNT_W'(updateAcc) - CNT_W'(deq);
            predictValid <= lookupAcc;
            if (lookupAcc) begin
                fwdHit <= hitD;
                fwdCtr <= hitCtrD;
            end
            heldCtr <= predictCtr;
        end
    end

    // Queue payload needs no reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (updateAcc) begin
            qIdx[wrPtr] <= updateIdx;
            qCtr[wrPtr] <= newCtr;
        end
    end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// tb_branch_predictor_ctrl
// Bench for branch_predictor_ctrl: directed steps followed by random
// traffic, checked every cycle against a transaction-level model (a list of
// pending table updates plus an image of the table contents).
module tb_branch_predictor_ctrl;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;
    localparam int QDEPTH  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lookupValid = 1'b0;
    logic [31:0]      lookupPc = '0;
    logic             lookupReady;
    logic             predictValid;
    logic             predictTaken;
    logic [1:0]       predictCtr;
    logic             updateValid = 1'b0;
    logic [31:0]      updatePc = '0;
    logic             updateTaken = 1'b0;
    logic [1:0]       updateCtr = '0;
    logic             updateReady;
    logic             memEn;
    logic             memWe;
    logic [IDX_W-1:0] memAddr;
    logic [1:0]       memWdata;
    logic [1:0]       memRdata;
    logic             initDone;

    branch_predictor_ctrl #(
        .ENTRIES(ENTRIES),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lookupValid (lookupValid),
        .lookupPc    (lookupPc),
        .lookupReady (lookupReady),
        .predictValid(predictValid),
        .predictTaken(predictTaken),
        .predictCtr  (predictCtr),
        .updateValid (updateValid),
        .updatePc    (updatePc),
        .updateTaken (updateTaken),
        .updateCtr   (updateCtr),
        .updateReady (updateReady),
        .memEn       (memEn),
        .memWe       (memWe),
        .memAddr     (memAddr),
        .memWdata    (memWdata),
        .memRdata    (memRdata),
        .initDone    (initDone)
    );

    always #5 clk = ~clk;

    // External table memory: single port, synchronous read.
    logic [1:0] mem [ENTRIES];
    always @(posedge clk) begin
        if (memEn && memWe) mem[memAddr] <= memWdata;
        if (memEn && !memWe) memRdata <= mem[memAddr];
    end

    // Reference model state.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       ctr;
    } upd_t;

    upd_t       pend[$];
    logic [1:0] refTab [ENTRIES];
    int         initCnt = 0;
    bit         expPv = 1'b0;
    logic [1:0] expCtr = 2'b00;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IDX_W-1:0] pcIdx(input logic [31:0] pc);
        return IDX_W'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [1:0] stepCtr(input logic [1:0] c, input bit taken);
        int n;
        n = int'(c) + (taken ? 1 : -1);
        if (n > 3) n = 3;
        if (n < 0) n = 0;
        return 2'(n);
    endfunction

    // Compare this cycle's outputs with the model, then advance the model.
    task automatic checkCycle();
        bit         isFull;
        bit         acc;
        bit         enq;
        logic [IDX_W-1:0] li;
        logic [IDX_W-1:0] ui;
        logic [1:0] nc;
        logic [1:0] pv;
        upd_t       e;

        chk("predictValid", predictValid, expPv);
        chk("predictCtr", predictCtr, expCtr);
        chk("predictTaken", predictTaken, expCtr[1]);

        if (initCnt < ENTRIES) begin
            chk("init_lookupReady", lookupReady, 0);
            chk("init_updateReady", updateReady, 0);
            chk("init_initDone", initDone, 0);
            chk("init_memEn", memEn, 1);
            chk("init_memWe", memWe, 1);
            chk("init_memAddr", memAddr, initCnt);
            chk("init_memWdata", memWdata, 1);
            refTab[initCnt] = 2'b01;
            initCnt++;
            expPv = 1'b0;
        end else begin
            isFull = (pend.size() == QDEPTH);
            chk("initDone", initDone, 1);
            chk("lookupReady", lookupReady, !isFull);
            chk("updateReady", updateReady, !isFull);
            li  = pcIdx(lookupPc);
            ui  = pcIdx(updatePc);
            nc  = stepCtr(updateCtr, updateTaken);
            acc = lookupValid && !isFull;
            enq = updateValid && !isFull;

            if (isFull || (!lookupValid && pend.size() > 0)) begin
                chk("wr_memEn", memEn, 1);
                chk("wr_memWe", memWe, 1);
                chk("wr_memAddr", memAddr, pend[0].idx);
                chk("wr_memWdata", memWdata, pend[0].ctr);
                refTab[pend[0].idx] = pend[0].ctr;
                void'(pend.pop_front());
            end else if (lookupValid) begin
                chk("rd_memEn", memEn, 1);
                chk("rd_memWe", memWe, 0);
                chk("rd_memAddr", memAddr, li);
                chk("rd_memWdata", memWdata, 0);
            end else begin
                chk("idle_memEn", memEn, 0);
            end

            // Prediction = table value with every pending update applied in order.
            pv = refTab[li];
            foreach (pend[k]) if (pend[k].idx == li) pv = pend[k].ctr;
            if (enq && ui == li) pv = nc;

            if (enq) begin
                e.idx = ui;
                e.ctr = nc;
                pend.push_back(e);
            end
            expPv = acc;
            if (acc) expCtr = pv;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) checkCycle();
        @(posedge clk);
        if (rst) begin
            pend.delete();
            initCnt = 0;
            expPv   = 1'b0;
            expCtr  = 2'b00;
        end
        #1;
    endtask

    task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv,
                         input logic [31:0] upc, input bit ut, input logic [1:0] uc);
        lookupValid = lv;
        lookupPc    = lpc;
        updateValid = uv;
        updatePc    = upc;
        updateTaken = ut;
        updateCtr   = uc;
    endtask

    task automatic idle(input int n);
        drive(0, 32'h0, 0, 32'h0, 0, 2'd0);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] randPc();
        return ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    task automatic randSteps(input int n, input int lvPct, input int uvPct);
        for (int i = 0; i < n; i++) begin
            drive(($urandom_range(0, 99) < lvPct), randPc(), ($urandom_range(0, 99) < uvPct),
                  randPc(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            step();
        end
    endtask

    initial begin
        // Reset and table clear.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(ENTRIES);
        chk("initDone_rises", initDone, 1);
        chk("lookupReady_run", lookupReady, 1);
        idle(1);

        // Simple lookup of a freshly cleared entry.
        drive(1, 32'h104, 0, 32'h0, 0, 2'd0);
        step();
        chk("lookup104_valid", predictValid, 1);
        chk("lookup104_ctr", predictCtr, 2'b01);
        idle(2);

        // Three updates to the same index, written in order.
        drive(0, 32'h0, 1, 32'h108, 1, 2'd3); step();
        drive(0, 32'h0, 1, 32'h108, 0, 2'd0); step();
        drive(0, 32'h0, 1, 32'h108, 1, 2'd1); step();
        idle(4);

        // Lookups saturating the port while the queue fills and drains.
        drive(1, 32'h300, 1, 32'h200, 1, 2'd0); step();
        drive(1, 32'h300, 1, 32'h204, 0, 2'd2); step();
        drive(1, 32'h300, 1, 32'h208, 1, 2'd2); step();
        drive(1, 32'h300, 1, 32'h20c, 0, 2'd1); step();
        drive(1, 32'h300, 0, 32'h0, 0, 2'd0);
        for (int i = 0; i < 4; i++) step();
        idle(6);

        // Forwarding from a queued entry, then from a same-cycle enqueue.
        drive(1, 32'h000, 1, 32'h114, 1, 2'd1); step();
        drive(1, 32'h114, 0, 32'h0, 0, 2'd0); step();
        chk("fwd_queued_ctr", predictCtr, 2'd2);
        chk("fwd_queued_taken", predictTaken, 1);
        drive(1, 32'h118, 1, 32'h118, 1, 2'd1); step();
        chk("fwd_same_ctr", predictCtr, 2'd2);
        chk("fwd_same_taken", predictTaken, 1);
        idle(4);

        // Random traffic with varying pressure.
        randSteps(200, 50, 50);
        randSteps(150, 90, 60);
        randSteps(150, 20, 80);
        idle(6);

        // Reset with three updates pending: none of them may reach memory.
        drive(1, 32'h0, 1, 32'h120, 1, 2'd2); step();
        drive(1, 32'h0, 1, 32'h124, 1, 2'd2); step();
        drive(1, 32'h0, 1, 32'h128, 1, 2'd2); step();
        drive(1, 32'h0, 0, 32'h0, 0, 2'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_predictValid", predictValid, 0);
        chk("rst_initDone", initDone, 0);
        idle(ENTRIES + 4);

        randSteps(200, 60, 60);
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
